conv_output_writer: RTL and testbench

- Receiving end of the conv accumulator send interface.
- Captures accumulator lanes flagged by ACC_send each cycle, applies ReLU plus signed saturation, and buffers results in a small FIFO.
- Drains one result per cycle to the output SRAM write port at sequential addresses.
- On matrix_done_flag, writes a 16'hFFFF end-of-matrix marker once every result of that matrix is written, mirroring the FFFF terminator on the input side.

---
 rtl/conv_output_writer.sv | 162 ++++++++++++++++
 tb/tb_conv_output_writer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_output_writer.sv
// Output stage of the conv accumulator: ReLU + saturation on each sent lane, a small
// multi-push FIFO, one SRAM write per cycle, and a 16'hFFFF marker after each matrix.
module conv_output_writer #(
  parameter int          ACC_W      = 20,
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 12,
  parameter int          FIFO_DEPTH = 8,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic                reset_datapath_n,
  input  logic [3:0]          ACC_send,
  input  logic [4*ACC_W-1:0]  acc_data,
  input  logic                matrix_done_flag,
  output logic                sram_write_enable,
  output logic [ADDR_W-1:0]   sram_write_address,
  output logic [DATA_W-1:0]   sram_write_data,
  output logic                writer_busy,
  output logic                matrix_written,
  output logic                fifo_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [DATA_W-1:0] MARKER  = '1;
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  // Non-negative values above SAT_MAX are exactly those with a bit set between
  // DATA_W-1 and the sign bit, so results never reach the all-ones marker.
  function automatic logic [DATA_W-1:0] relu_sat(input logic [ACC_W-1:0] v);
    logic [DATA_W-1:0] r;
    if (v[ACC_W-1])                 r = '0;
    else if (|v[ACC_W-2:DATA_W-1])  r = SAT_MAX;
    else                            r = v[DATA_W-1:0];
    return r;
  endfunction

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, marker_cnt_q, marker_cnt_d;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q;
  logic              we_q, mw_q, ovf_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  logic              rst_all, pop, overflow_hit;
  logic [CNT_W-1:0]  free_slots, n_push, count_after;
  logic [3:0]        lane_we;
  logic [PTR_W-1:0]  lane_slot [4];

  assign rst_all = !reset_b || !reset_datapath_n;

  // A DRAIN entered with nothing owed must not pop next-matrix data ahead of the marker.
  assign pop = (count_q != '0) && (state_q != S_DONE) &&
               !(state_q == S_DRAIN && marker_cnt_q == '0);

  assign free_slots = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(pop);

  // NOTE: n_push is a running tally inside one combinational pass, so it is updated
  // with blocking assignments and defaulted first to avoid inferring a latch.
  always_comb begin
    n_push       = '0;
    overflow_hit = 1'b0;
    lane_we      = '0;
    for (int i = 0; i < 4; i++) begin
      lane_slot[i] = wr_ptr_q + PTR_W'(n_push);
      if (ACC_send[i]) begin
        if (n_push < free_slots) begin
          lane_we[i] = 1'b1;
          n_push     = n_push + 1'b1;
        end else begin
          overflow_hit = 1'b1;
        end
      end
    end
  end

  assign count_after = count_q - CNT_W'(pop) + n_push;

  always_comb begin
    state_d      = state_q;
    marker_cnt_d = marker_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (matrix_done_flag) begin
          state_d      = S_DRAIN;
          marker_cnt_d = count_after;
        end else if (count_q != '0 || n_push != '0) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (matrix_done_flag) begin
          state_d      = S_DRAIN;
          marker_cnt_d = count_after;
        end else if (count_after == '0) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        marker_cnt_d = marker_cnt_q - CNT_W'(pop);
        if (marker_cnt_d == '0) state_d = S_DONE;
      end
      default: state_d = (count_after != '0) ? S_WRITE : S_IDLE;
    endcase
  end

  // NOTE: the result store has no reset; emptiness is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (lane_we[i]) mem_q[lane_slot[i]] <= relu_sat(acc_data[i*ACC_W +: ACC_W]);
    end
  end

  // NOTE: all state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      marker_cnt_q <= '0;
      next_addr_q  <= ADDR_W'(BASE_ADDR);
      addr_q       <= ADDR_W'(BASE_ADDR);
      data_q       <= '0;
      we_q         <= 1'b0;
      mw_q         <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_q + PTR_W'(pop);
      wr_ptr_q     <= wr_ptr_q + PTR_W'(n_push);
      count_q      <= count_after;
      marker_cnt_q <= marker_cnt_d;
      ovf_q        <= ovf_q | overflow_hit;
      we_q         <= pop || (state_q == S_DONE);
      mw_q         <= (state_q == S_DONE);
      if (pop || state_q == S_DONE) begin
        data_q      <= (state_q == S_DONE) ? MARKER : mem_q[rd_ptr_q];
        addr_q      <= next_addr_q;
        next_addr_q <= next_addr_q + 1'b1;
      end
    end
  end

  assign sram_write_enable  = we_q;
  assign sram_write_address = addr_q;
  assign sram_write_data    = data_q;
  assign matrix_written     = mw_q;
  assign fifo_overflow      = ovf_q;
  assign writer_busy        = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_conv_output_writer.sv
// Scoreboard bench for conv_output_writer: expected words are queued as lanes are sent
// and compared, with their running address, whenever the DUT writes.
module tb_conv_output_writer;

  localparam int ACC_W      = 20;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int FIFO_DEPTH = 8;
  localparam logic [DATA_W-1:0] MARK = 16'hFFFF;

  logic                clk = 1'b0;
  logic                reset_b = 1'b0;
  logic                reset_datapath_n = 1'b1;
  logic [3:0]          ACC_send = '0;
  logic [4*ACC_W-1:0]  acc_data = '0;
  logic                matrix_done_flag = 1'b0;
  logic                sram_write_enable;
  logic [ADDR_W-1:0]   sram_write_address;
  logic [DATA_W-1:0]   sram_write_data;
  logic                writer_busy;
  logic                matrix_written;
  logic                fifo_overflow;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [ADDR_W-1:0] exp_addr = '0;

  always #5 clk = ~clk;

  conv_output_writer #(
    .ACC_W(ACC_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .FIFO_DEPTH(FIFO_DEPTH), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .reset_b(reset_b), .reset_datapath_n(reset_datapath_n),
    .ACC_send(ACC_send), .acc_data(acc_data), .matrix_done_flag(matrix_done_flag),
    .sram_write_enable(sram_write_enable), .sram_write_address(sram_write_address),
    .sram_write_data(sram_write_data), .writer_busy(writer_busy),
    .matrix_written(matrix_written), .fifo_overflow(fifo_overflow)
  );

  function automatic logic [DATA_W-1:0] ref_relu(input logic [ACC_W-1:0] raw);
    int v;
    v = int'($signed(raw));
    if (v < 0)     return '0;
    if (v > 32767) return 16'h7FFF;
    return DATA_W'(v);
  endfunction

  // One clock: observe outputs of the previous edge at negedge, then cross the next edge.
  task automatic step();
    logic [DATA_W-1:0] e;
    @(negedge clk);
    if (sram_write_enable === 1'b1) begin
      n_writes++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write: got addr=%0d data=%h mw=%b, want no write",
                 sram_write_address, sram_write_data, matrix_written);
      end else begin
        e = exp_q.pop_front();
        if (sram_write_data !== e || sram_write_address !== exp_addr ||
            matrix_written !== (e == MARK)) begin
          n_err++;
          $display("FAIL sb_write: got addr=%0d data=%h mw=%b, want addr=%0d data=%h mw=%b",
                   sram_write_address, sram_write_data, matrix_written,
                   exp_addr, e, (e == MARK));
        end
        exp_addr = exp_addr + 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] mask, input logic [ACC_W-1:0] l0, l1, l2, l3,
                       input logic flag);
    ACC_send         = mask;
    acc_data         = {l3, l2, l1, l0};
    matrix_done_flag = flag;
  endtask

  task automatic idle_inputs();
    drive(4'b0000, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic expect_lanes(input logic [3:0] mask, input logic [ACC_W-1:0] l0, l1, l2, l3);
    logic [ACC_W-1:0] lanes [4];
    lanes = '{l0, l1, l2, l3};
    for (int i = 0; i < 4; i++) if (mask[i]) exp_q.push_back(ref_relu(lanes[i]));
  endtask

  task automatic do_reset(input bit datapath);
    idle_inputs();
    if (datapath) reset_datapath_n = 1'b0;
    else          reset_b = 1'b0;
    step();
    reset_b = 1'b1;
    reset_datapath_n = 1'b1;
    exp_q.delete();
    exp_addr = '0;
    n_cmp++;
    if ({sram_write_enable, matrix_written, fifo_overflow, writer_busy,
         sram_write_address, sram_write_data} !== '0) begin
      n_err++;
      $display("FAIL reset_state(dp=%0b): got we=%b mw=%b ovf=%b busy=%b addr=%0d data=%h, want all 0",
               datapath, sram_write_enable, matrix_written, fifo_overflow, writer_busy,
               sram_write_address, sram_write_data);
    end
  endtask

  task automatic wait_idle(input int budget);
    int i;
    idle_inputs();
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && writer_busy === 1'b0) break;
      step();
    end
    n_cmp++;
    if (exp_q.size() != 0 || writer_busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d words outstanding busy=%b, want 0 and busy=0",
               exp_q.size(), writer_busy);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    step();
    n_cmp++;
    if (sram_write_enable !== 1'b0 || writer_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_quiet: got we=%b busy=%b, want 0 0", sram_write_enable, writer_busy);
    end
  endtask

  task automatic test_single_push();
    do_reset(1'b0);
    drive(4'b0001, 20'd100, '0, '0, '0, 1'b0);
    expect_lanes(4'b0001, 20'd100, '0, '0, '0);
    step();
    idle_inputs();
    step();
    n_cmp++;
    if (sram_write_enable !== 1'b1 || sram_write_address !== 4'd0 || sram_write_data !== 16'd100) begin
      n_err++;
      $display("FAIL single_latency: got we=%b addr=%0d data=%0d, want 1 0 100",
               sram_write_enable, sram_write_address, sram_write_data);
    end
    step();
    n_cmp++;
    if (writer_busy !== 1'b0 || sram_write_enable !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle: got busy=%b we=%b, want 0 0", writer_busy, sram_write_enable);
    end
  endtask

  task automatic test_saturation();
    do_reset(1'b0);
    drive(4'b1100, '0, '0, 20'hFFFFB, 20'h09000, 1'b0);
    expect_lanes(4'b1100, '0, '0, 20'hFFFFB, 20'h09000);
    step();
    idle_inputs();
    step();
    n_cmp++;
    if (sram_write_enable !== 1'b1 || sram_write_address !== 4'd0 || sram_write_data !== 16'd0) begin
      n_err++;
      $display("FAIL sat_negative: got we=%b addr=%0d data=%0d, want 1 0 0",
               sram_write_enable, sram_write_address, sram_write_data);
    end
    step();
    n_cmp++;
    if (sram_write_enable !== 1'b1 || sram_write_address !== 4'd1 || sram_write_data !== 16'd32767) begin
      n_err++;
      $display("FAIL sat_positive: got we=%b addr=%0d data=%0d, want 1 1 32767",
               sram_write_enable, sram_write_address, sram_write_data);
    end
    // Boundary values: 32768, 32767, 65535, most-negative accumulator.
    drive(4'b1111, 20'h08000, 20'h07FFF, 20'h0FFFF, 20'h80000, 1'b0);
    expect_lanes(4'b1111, 20'h08000, 20'h07FFF, 20'h0FFFF, 20'h80000);
    step();
    wait_idle(20);
  endtask

  task automatic test_overflow();
    int base;
    do_reset(1'b0);
    base = n_writes;
    for (int c = 0; c < 3; c++) begin
      drive(4'hF, ACC_W'(c*4+1), ACC_W'(c*4+2), ACC_W'(c*4+3), ACC_W'(c*4+4), 1'b0);
      expect_lanes((c == 2) ? 4'b0011 : 4'b1111,
                   ACC_W'(c*4+1), ACC_W'(c*4+2), ACC_W'(c*4+3), ACC_W'(c*4+4));
      step();
    end
    n_cmp++;
    if (fifo_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_set: got %b, want 1", fifo_overflow);
    end
    wait_idle(30);
    n_cmp++;
    if (n_writes - base != 10 || fifo_overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_sticky: got writes=%0d ovf=%b, want 10 1", n_writes - base, fifo_overflow);
    end
    do_reset(1'b1);
  endtask

  task automatic test_marker_order();
    do_reset(1'b0);
    drive(4'b1100, '0, '0, 20'd300, 20'd400, 1'b1);
    expect_lanes(4'b1100, '0, '0, 20'd300, 20'd400);
    exp_q.push_back(MARK);
    step();
    idle_inputs();
    step();
    drive(4'b0011, 20'd500, 20'd600, '0, '0, 1'b0);
    expect_lanes(4'b0011, 20'd500, 20'd600, '0, '0);
    step();
    wait_idle(20);
  endtask

  task automatic test_empty_flag();
    do_reset(1'b0);
    drive(4'b0000, '0, '0, '0, '0, 1'b1);
    exp_q.push_back(MARK);
    step();
    idle_inputs();
    step();
    n_cmp++;
    if (sram_write_enable !== 1'b0) begin
      n_err++;
      $display("FAIL empty_flag_early: got we=%b, want 0", sram_write_enable);
    end
    step();
    n_cmp++;
    if (sram_write_enable !== 1'b1 || sram_write_data !== MARK || matrix_written !== 1'b1 ||
        sram_write_address !== 4'd0 || writer_busy !== 1'b0) begin
      n_err++;
      $display("FAIL empty_flag_marker: got we=%b data=%h mw=%b addr=%0d busy=%b, want 1 ffff 1 0 0",
               sram_write_enable, sram_write_data, matrix_written, sram_write_address, writer_busy);
    end
    wait_idle(5);
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) begin
      drive(4'b0001, ACC_W'(i*3 + 7), '0, '0, '0, 1'b0);
      expect_lanes(4'b0001, ACC_W'(i*3 + 7), '0, '0, '0);
      step();
    end
    wait_idle(10);
    n_cmp++;
    if (sram_write_address !== 4'd0 || n_writes == 0) begin
      n_err++;
      $display("FAIL wrap_addr: got last addr=%0d, want 0", sram_write_address);
    end
  endtask

  task automatic test_reset_mid_drain();
    do_reset(1'b0);
    drive(4'hF, 20'd1000, 20'd2000, 20'd3000, 20'd4000, 1'b1);
    expect_lanes(4'hF, 20'd1000, 20'd2000, 20'd3000, 20'd4000);
    exp_q.push_back(MARK);
    step();
    idle_inputs();
    step();
    do_reset(1'b0);
    repeat (8) step();
    n_cmp++;
    if (sram_write_enable !== 1'b0 || matrix_written !== 1'b0 || writer_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_quiet: got we=%b mw=%b busy=%b, want 0 0 0",
               sram_write_enable, matrix_written, writer_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]       mask;
    logic [ACC_W-1:0] l [4];
    do_reset(1'b0);
    for (int it = 0; it < 16; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0:       l[i] = ACC_W'($urandom_range(0, 32767));
          1:       l[i] = ACC_W'($urandom) | 20'h80000;
          default: l[i] = ACC_W'($urandom);
        endcase
      end
      drive(mask, l[0], l[1], l[2], l[3], 1'b0);
      expect_lanes(mask, l[0], l[1], l[2], l[3]);
      step();
      idle_inputs();
      repeat ($countones(mask)) step();
    end
    wait_idle(20);
    n_cmp++;
    if (fifo_overflow !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_overflow: got %b, want 0", fifo_overflow);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_saturation();
    test_overflow();
    test_marker_order();
    test_empty_flag();
    test_wrap();
    test_reset_mid_drain();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
